sum_sched: RTL and testbench
============================

SUM_SCHED -- requirements
Module: sum_sched

Interface
REQ-001 SHALL have parameter IN_BITS, default 8: signed width of each input term.
REQ-002 SHALL have parameter IN_TERMS, default 8: number of terms per sum.
REQ-003 SHALL have parameter OUT_BITS, default 12: signed width of the result.
REQ-004 SHALL have parameter LANES, default 2: terms added per cycle, 1..IN_TERMS.
REQ-005 SHALL have port clk  input  1: single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port in_valid  input  1: term vector offered.
REQ-008 SHALL have port in_ready  output  1: vector will be accepted.
REQ-009 SHALL have port in  input  IN_TERMS x IN_BITS signed: term vector.
REQ-010 SHALL have port out_valid  output  1: result available.
REQ-011 SHALL have port out_ready  input  1: consumer takes result.
REQ-012 SHALL have port out  output  OUT_BITS signed: sum of all terms.
REQ-013 SHALL have port ovf  output  1: result exceeded OUT_BITS range, valid with out_valid.
REQ-014 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-015 SHALL define STEPS = ceil(IN_TERMS/LANES).
REQ-016 SHALL implement FSM IDLE -> ACCUM -> DONE -> IDLE.
REQ-017 SHALL drive in_ready high only in IDLE.
REQ-018 SHALL accept a vector when in_valid and in_ready are high at a clock edge: capture all terms, clear the accumulator and step counter, go to ACCUM.
REQ-019 SHALL ignore in_valid outside IDLE, with no effect on stored terms.
REQ-020 SHALL in each ACCUM cycle k (0..STEPS-1) add terms k*LANES..k*LANES+LANES-1, sign-extended, to the accumulator; indices >= IN_TERMS contribute 0.
REQ-021 SHALL keep the accumulator OUT_BITS+clog2(IN_TERMS)+1 bits wide, so that no internal overflow occurs.
REQ-022 SHALL go to DONE at the edge that completes step STEPS-1; out_valid is therefore first high STEPS cycles after the accept edge.
REQ-023 SHALL present out as the low OUT_BITS bits of the accumulator, giving two's-complement wrap.
REQ-024 SHALL set ovf when the full accumulator is outside [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
REQ-025 SHALL hold out_valid, out and ovf stable in DONE until out_ready is high, then return to IDLE at that edge.
REQ-026 SHALL NOT assert in_ready in the same cycle as out_valid; minimum period between accepts is STEPS+2 cycles.
REQ-027 SHALL drive out and ovf to 0 whenever out_valid is low.

Reset
REQ-028 SHALL on rst_n low, immediately and asynchronously: enter IDLE and clear the accumulator, step counter, captured terms, out, ovf, out_valid and busy to 0.
REQ-029 SHALL drive in_ready to 1 at reset; reset in ACCUM or DONE discards the pending sum with no output.
REQ-030 SHALL accept a new vector at the first clock edge after rst_n deasserts.

Structure
REQ-031 SHALL place the state enum (IDLE, ACCUM, DONE) and a steps(IN_TERMS, LANES) function in package sum_sched_pkg.
REQ-032 SHALL instantiate one sub-module, sum_sched_lane: a combinational LANES-input signed adder producing the per-step partial sum at accumulator width.
REQ-033 SHALL let the lane select be a mux indexed by the step counter; no other sub-modules.

Verification (IN_BITS=8, IN_TERMS=5, OUT_BITS=12, LANES=2, STEPS=3 unless stated)
REQ-034 SHALL test: in={1,2,3,4,5} accepted at edge E -> out_valid high after E+3, out=15, ovf=0.
REQ-035 SHALL test: in={-128 x5} -> out=-640, ovf=0; then OUT_BITS=8 with in={100,100,0,0,0} -> out=-56, ovf=1.
REQ-036 SHALL test: out_ready low for 4 cycles in DONE -> out, ovf, out_valid unchanged, in_ready=0, busy=1; out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-037 SHALL test: rst_n pulsed low during ACCUM step 1 -> out_valid=0, busy=0, in_ready=1 at once; the next vector {5,5,5,5,5} gives 25.
REQ-038 SHALL test: in_valid held high with changing data while busy -> result reflects only the accepted vector.
REQ-039 SHALL test: LANES=5 (STEPS=1) with {1,1,1,1,1} -> out=5 one cycle after accept; LANES=1 -> out_valid after 5 cycles.

Source files
------------

// File: rtl/sum_sched_pkg.sv
// Shared types and helpers for the multi-cycle signed term summer.
package sum_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of accumulate cycles needed to cover all terms, LANES at a time.
    function automatic int steps(input int terms, input int lanes);
        return (terms + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/sum_sched_lane.sv
// Combinational adder: sign-extends LANES packed terms to ACC_W bits and sums them.
module sum_sched_lane #(
    parameter int IN_BITS = 8,
    parameter int LANES   = 2,
    parameter int ACC_W   = 16
) (
    input  logic [LANES*IN_BITS-1:0] i_terms,
    output logic signed [ACC_W-1:0]  o_sum
);

    always_comb begin
        // NOTE: combinational accumulation in a loop must use blocking '=' so each
        // iteration sees the previous partial sum; the default first avoids a latch.
        o_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            o_sum = o_sum + ACC_W'($signed(i_terms[j*IN_BITS +: IN_BITS]));
        end
    end

endmodule

// File: rtl/sum_sched.sv
// Captures a vector of signed terms and sums them LANES per cycle, then holds the
// wrapped result with an overflow flag until the consumer takes it.
module sum_sched
    import sum_sched_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int IN_TERMS = 8,
    parameter int OUT_BITS = 12,
    parameter int LANES    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_TERMS*IN_BITS-1:0]  in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_BITS-1:0]   out,
    output logic                         ovf,
    output logic                         busy
);

    localparam int STEPS  = steps(IN_TERMS, LANES);
    localparam int ACC_W  = OUT_BITS + $clog2(IN_TERMS) + 1;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int LANE_W = LANES * IN_BITS;
    localparam int PAD_W  = STEPS * LANE_W;

    state_t                       r_state;
    logic [IN_TERMS*IN_BITS-1:0]  r_terms;
    logic signed [ACC_W-1:0]      r_acc;
    logic [STEP_W-1:0]            r_step;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic                         r_busy;
    logic                         r_ovf;
    logic signed [OUT_BITS-1:0]   r_out;

    logic [PAD_W-1:0]             w_padded;
    logic [LANE_W-1:0]            w_lane_terms;
    logic signed [ACC_W-1:0]      w_partial;
    logic signed [ACC_W-1:0]      w_acc_next;
    logic [ACC_W-OUT_BITS:0]      w_upper;
    logic                         w_ovf;

    // Zero-padding to a whole number of steps makes missing trailing terms add 0.
    assign w_padded     = PAD_W'(r_terms);
    assign w_lane_terms = w_padded[int'(r_step)*LANE_W +: LANE_W];

    sum_sched_lane #(
        .IN_BITS (IN_BITS),
        .LANES   (LANES),
        .ACC_W   (ACC_W)
    ) u_lane (
        .i_terms (w_lane_terms),
        .o_sum   (w_partial)
    );

    assign w_acc_next = r_acc + w_partial;
    // Result fits OUT_BITS only if all bits above the output sign bit match it.
    assign w_upper    = w_acc_next[ACC_W-1:OUT_BITS-1];
    assign w_ovf      = !((&w_upper) || !(|w_upper));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking '<='; the term store is reset too, since a
            // reset must leave no trace of an abandoned vector.
            r_state     <= IDLE;
            r_terms     <= '0;
            r_acc       <= '0;
            r_step      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out       <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_terms    <= in;
                        r_acc      <= '0;
                        r_step     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= w_acc_next;
                    if (r_step == STEP_W'(STEPS - 1)) begin
                        r_out       <= w_acc_next[OUT_BITS-1:0];
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sum_sched.sv
// Scoreboard bench for sum_sched: four configurations share clock and reset.
module tb_sum_sched;

    typedef struct {
        int val;
        bit ovf;
        int acc_cyc;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [39:0]        tb_in      [4];
    logic               in_valid_s [4];
    logic               out_ready_s[4];
    logic               in_ready_s [4];
    logic               out_valid_s[4];
    logic               busy_s     [4];
    logic               ovf_s      [4];
    logic signed [15:0] out_x      [4];
    logic               prev_v     [4];

    logic signed [11:0] out0, out2, out3;
    logic signed [7:0]  out1;

    exp_t q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: default bench config (STEPS=3); u1: OUT_BITS=8; u2: LANES=5; u3: LANES=1
    sum_sched #(.IN_BITS(8), .IN_TERMS(5), .OUT_BITS(12), .LANES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in(tb_in[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .out(out0), .ovf(ovf_s[0]), .busy(busy_s[0]));
    sum_sched #(.IN_BITS(8), .IN_TERMS(5), .OUT_BITS(8), .LANES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in(tb_in[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .out(out1), .ovf(ovf_s[1]), .busy(busy_s[1]));
    sum_sched #(.IN_BITS(8), .IN_TERMS(5), .OUT_BITS(12), .LANES(5)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .in(tb_in[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .out(out2), .ovf(ovf_s[2]), .busy(busy_s[2]));
    sum_sched #(.IN_BITS(8), .IN_TERMS(5), .OUT_BITS(12), .LANES(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
        .in(tb_in[3]), .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]),
        .out(out3), .ovf(ovf_s[3]), .busy(busy_s[3]));

    assign out_x[0] = 16'(out0);
    assign out_x[1] = 16'(out1);
    assign out_x[2] = 16'(out2);
    assign out_x[3] = 16'(out3);

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] pack5(input int a, input int b, input int c,
                                          input int d, input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic int steps_of(input int i);
        case (i)
            2:       return 1;
            3:       return 5;
            default: return 3;
        endcase
    endfunction

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int q_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic pop_exp(input int i, output exp_t e);
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic send(input int i, input logic [39:0] v, input int exp_val,
                        input bit exp_ovf, input bit expect_out);
        exp_t e;
        int   n;
        in_valid_s[i] = 1'b1;
        tb_in[i]      = v;
        n = 0;
        while (!in_ready_s[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_s[i]) begin
            check($sformatf("u%0d accept timeout", i), 0, 1);
        end else if (expect_out) begin
            e.val     = exp_val;
            e.ovf     = exp_ovf;
            e.acc_cyc = cyc + 1;
            e.lat     = steps_of(i);
            push_exp(i, e);
        end
        @(negedge clk);
        in_valid_s[i] = 1'b0;
    endtask

    // Monitor: compare each new result against the scoreboard and watch idle outputs.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_n && out_valid_s[i] && !prev_v[i]) begin
                if (q_size(i) == 0) begin
                    check($sformatf("u%0d unexpected result", i), int'(out_x[i]), 0);
                    n_fail += (int'(out_x[i]) == 0) ? 1 : 0;
                end else begin
                    exp_t e;
                    pop_exp(i, e);
                    check($sformatf("u%0d out", i), int'(out_x[i]), e.val);
                    check($sformatf("u%0d ovf", i), int'(ovf_s[i]), int'(e.ovf));
                    check($sformatf("u%0d latency", i), cyc - e.acc_cyc, e.lat);
                end
            end
            if (out_valid_s[i]) begin
                check($sformatf("u%0d in_ready during out_valid", i), int'(in_ready_s[i]), 0);
            end else begin
                check($sformatf("u%0d out idle zero", i), int'(out_x[i]), 0);
                check($sformatf("u%0d ovf idle zero", i), int'(ovf_s[i]), 0);
            end
            prev_v[i] <= out_valid_s[i];
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            tb_in[i]       = '0;
            in_valid_s[i]  = 1'b0;
            out_ready_s[i] = 1'b1;
            prev_v[i]      = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("u%0d reset in_ready", i), int'(in_ready_s[i]), 1);
            check($sformatf("u%0d reset out_valid", i), int'(out_valid_s[i]), 0);
            check($sformatf("u%0d reset busy", i), int'(busy_s[i]), 0);
        end
        rst_n = 1'b1;

        // First edge after reset release accepts; basic sums and sign handling.
        send(0, pack5(1, 2, 3, 4, 5), 15, 1'b0, 1'b1);
        send(0, pack5(-128, -128, -128, -128, -128), -640, 1'b0, 1'b1);
        send(0, pack5(127, -1, -128, 50, -60), -12, 1'b0, 1'b1);

        // Narrow output: wrap and overflow boundaries.
        send(1, pack5(100, 100, 0, 0, 0), -56, 1'b1, 1'b1);
        send(1, pack5(100, 27, 0, 0, 0), 127, 1'b0, 1'b1);
        send(1, pack5(-100, -28, 0, 0, 0), -128, 1'b0, 1'b1);
        send(1, pack5(-128, -128, 0, 0, 0), 0, 1'b1, 1'b1);
        send(1, pack5(100, 28, 0, 0, 0), -128, 1'b1, 1'b1);

        // Other lane counts.
        send(2, pack5(1, 1, 1, 1, 1), 5, 1'b0, 1'b1);
        send(2, pack5(-7, 20, -3, 100, 90), 200, 1'b0, 1'b1);
        send(3, pack5(1, 2, 3, 4, 5), 15, 1'b0, 1'b1);

        // Backpressure: result must hold while out_ready is low.
        out_ready_s[0] = 1'b0;
        send(0, pack5(10, 20, 30, 40, 50), 150, 1'b0, 1'b1);
        n = 0;
        while (!out_valid_s[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold reached DONE", int'(out_valid_s[0]), 1);
        for (int k = 0; k < 4; k++) begin
            check("hold out", int'(out_x[0]), 150);
            check("hold ovf", int'(ovf_s[0]), 0);
            check("hold out_valid", int'(out_valid_s[0]), 1);
            check("hold in_ready", int'(in_ready_s[0]), 0);
            check("hold busy", int'(busy_s[0]), 1);
            @(negedge clk);
        end
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        check("release out_valid", int'(out_valid_s[0]), 0);
        check("release in_ready", int'(in_ready_s[0]), 1);
        check("release busy", int'(busy_s[0]), 0);

        // Reset during ACCUM step 1 discards the pending sum.
        send(0, pack5(9, 9, 9, 9, 9), 45, 1'b0, 1'b0);
        @(negedge clk);
        check("pre-reset busy", int'(busy_s[0]), 1);
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", int'(out_valid_s[0]), 0);
        check("async reset busy", int'(busy_s[0]), 0);
        check("async reset in_ready", int'(in_ready_s[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, pack5(5, 5, 5, 5, 5), 25, 1'b0, 1'b1);

        // in_valid kept high with changing data while busy must be ignored.
        send(0, pack5(1, 1, 1, 1, 1), 5, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            in_valid_s[0] = 1'b1;
            tb_in[0]      = pack5(50 + k, -20, 33, 7, 99);
            @(negedge clk);
        end
        in_valid_s[0] = 1'b0;

        // Drain the scoreboard with a bounded wait.
        n = 0;
        while ((q_size(0) + q_size(1) + q_size(2) + q_size(3)) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", q_size(0) + q_size(1) + q_size(2) + q_size(3), 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
